// File: rtl/vga_pkg.sv
// Shared VGA constants, coordinate type and rectangle config payload.
//   SCREEN_W/SCREEN_H : active raster size
//   DIM_W             : coordinate/size field width
//   NUM_RECT/IDX_W    : rectangle channel count and index width
package vga_pkg;

    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SCREEN_H = 480;
    localparam int unsigned DIM_W    = 10;
    localparam int unsigned NUM_RECT = 4;
    localparam int unsigned IDX_W    = 2;

    typedef logic [DIM_W-1:0] coord_t;

    typedef struct packed {
        logic   en;
        coord_t x;
        coord_t y;
        coord_t w;
        coord_t h;
    } rect_cfg_t;

endpackage

// File: rtl/rect_region_scanner_if.sv
// Pixel strobe, config write and hit report bundle for rect_region_scanner.
//   master : timing generator / config side (drives strobes and config)
//   slave  : the scanner (drives the registered hit report)
interface rect_region_scanner_if;
    import vga_pkg::*;

    logic                frame_start;
    logic                pix_valid;
    logic                cfg_we;
    logic [IDX_W-1:0]    cfg_idx;
    logic                cfg_en;
    coord_t              cfg_x;
    coord_t              cfg_y;
    coord_t              cfg_w;
    coord_t              cfg_h;
    logic                hit_valid;
    logic [NUM_RECT-1:0] hit_vec;
    logic                hit_any;
    logic [IDX_W-1:0]    hit_idx;
    coord_t              pix_x;
    coord_t              pix_y;

    modport master (
        output frame_start, pix_valid, cfg_we, cfg_idx, cfg_en,
               cfg_x, cfg_y, cfg_w, cfg_h,
        input  hit_valid, hit_vec, hit_any, hit_idx, pix_x, pix_y
    );

    modport slave (
        input  frame_start, pix_valid, cfg_we, cfg_idx, cfg_en,
               cfg_x, cfg_y, cfg_w, cfg_h,
        output hit_valid, hit_vec, hit_any, hit_idx, pix_x, pix_y
    );

endinterface

// File: rtl/rect_contains.sv
// Combinational single-rectangle containment test.
//   x, y  : pixel coordinate
//   rect  : rectangle config (enable, top-left, size)
//   hit_c : pixel lies inside (left/top inclusive, right/bottom exclusive)
module rect_contains
    import vga_pkg::*;
(
    input  coord_t    x,
    input  coord_t    y,
    input  rect_cfg_t rect,
    output logic      hit_c
);

    // One extra bit so rectangles running off the screen never wrap to 0.
    logic [DIM_W:0] x_end_c;
    logic [DIM_W:0] y_end_c;

    assign x_end_c = {1'b0, rect.x} + {1'b0, rect.w};
    assign y_end_c = {1'b0, rect.y} + {1'b0, rect.h};

    assign hit_c = rect.en
                && (x >= rect.x) && ({1'b0, x} < x_end_c)
                && (y >= rect.y) && ({1'b0, y} < y_end_c);

endmodule

// File: rtl/rect_region_scanner.sv
// Multi-rectangle hit detector for the VGA pixel stream.
//   clock, reset : system clock, synchronous active-high reset
//   bus          : pixel strobes and config writes in, registered hit report out
module rect_region_scanner
    import vga_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    rect_region_scanner_if.slave bus
);

    coord_t              cnt_x;
    coord_t              cnt_y;
    coord_t              cur_x_c;
    coord_t              cur_y_c;
    rect_cfg_t           shadow [NUM_RECT];
    rect_cfg_t           active [NUM_RECT];
    rect_cfg_t           eval_c [NUM_RECT];
    logic [NUM_RECT-1:0] vec_c;
    logic [IDX_W-1:0]    idx_c;

    // frame_start forces the current pixel to the origin, overriding any wrap.
    assign cur_x_c = bus.frame_start ? '0 : cnt_x;
    assign cur_y_c = bus.frame_start ? '0 : cnt_y;

    // Raster position counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_x <= '0;
            cnt_y <= '0;
        end else if (bus.pix_valid) begin
            if (32'(cur_x_c) == SCREEN_W - 1) begin
                cnt_x <= '0;
                cnt_y <= (32'(cur_y_c) == SCREEN_H - 1) ? '0 : cur_y_c + DIM_W'(1);
            end else begin
                cnt_x <= cur_x_c + DIM_W'(1);
                cnt_y <= cur_y_c;
            end
        end else if (bus.frame_start) begin
            cnt_x <= '0;
            cnt_y <= '0;
        end
    end

    // Shadow/active config; the copy samples shadow before a coincident write.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < NUM_RECT; k++) begin
                shadow[k] <= '0;
                active[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_RECT; k++) begin
                if (bus.cfg_we && (bus.cfg_idx == IDX_W'(k))) begin
                    shadow[k] <= '{en: bus.cfg_en, x: bus.cfg_x, y: bus.cfg_y,
                                   w: bus.cfg_w,   h: bus.cfg_h};
                end
            end
            if (bus.frame_start) begin
                active <= shadow;
            end
        end
    end

    // The origin pixel of a new frame already sees the config being loaded.
    always_comb begin
        for (int k = 0; k < NUM_RECT; k++) begin
            eval_c[k] = bus.frame_start ? shadow[k] : active[k];
        end
    end

    for (genvar g = 0; g < NUM_RECT; g++) begin : g_rect
        rect_contains u_rect_contains (
            .x     (cur_x_c),
            .y     (cur_y_c),
            .rect  (eval_c[g]),
            .hit_c (vec_c[g])
        );
    end

    // Priority encoder, lowest index wins.
    always_comb begin
        idx_c = '0;
        for (int k = NUM_RECT - 1; k >= 0; k--) begin
            if (vec_c[k]) begin
                idx_c = IDX_W'(k);
            end
        end
    end

    // Registered hit report; coordinates hold when no pixel is strobed.
    always_ff @(posedge clock) begin
        if (reset) begin
            bus.hit_valid <= 1'b0;
            bus.hit_vec   <= '0;
            bus.hit_any   <= 1'b0;
            bus.hit_idx   <= '0;
            bus.pix_x     <= '0;
            bus.pix_y     <= '0;
        end else begin
            bus.hit_valid <= bus.pix_valid;
            bus.hit_vec   <= bus.pix_valid ? vec_c : '0;
            bus.hit_any   <= bus.pix_valid & (|vec_c);
            bus.hit_idx   <= bus.pix_valid ? idx_c : '0;
            if (bus.pix_valid) begin
                bus.pix_x <= cur_x_c;
                bus.pix_y <= cur_y_c;
            end
        end
    end

endmodule

// File: tb/tb_rect_region_scanner.sv
// Directed self-checking bench for rect_region_scanner.
module tb_rect_region_scanner;

    logic clk;
    logic rst;

    rect_region_scanner_if bus ();

    rect_region_scanner dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Bench-side raster position of the next strobed pixel.
    int ex;
    int ey;
    int hits_ch [4];
    int any_cnt;
    int coord_err;
    int valid_err;
    int hold_err;
    int cons_err;
    logic [9:0] last_x;
    logic [9:0] last_y;
    logic [3:0] vmem [24][640];
    logic [1:0] imem [24][640];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic clear_stats();
        for (int k = 0; k < 4; k++) hits_ch[k] = 0;
        any_cnt   = 0;
        coord_err = 0;
        valid_err = 0;
        hold_err  = 0;
        cons_err  = 0;
        for (int y = 0; y < 24; y++) begin
            for (int x = 0; x < 640; x++) begin
                vmem[y][x] = 4'bxxxx;
                imem[y][x] = 2'bxx;
            end
        end
    endtask

    // One clock with the given strobes; records and checks what comes back.
    task automatic do_pix(input logic fs, input logic pv);
        bus.frame_start = fs;
        bus.pix_valid   = pv;
        @(posedge clk);
        #1;
        bus.frame_start = 1'b0;
        bus.pix_valid   = 1'b0;
        bus.cfg_we      = 1'b0;
        if (fs) begin
            ex = 0;
            ey = 0;
        end
        if (pv) begin
            if (bus.hit_valid !== 1'b1) valid_err++;
            if (bus.pix_x !== 10'(ex) || bus.pix_y !== 10'(ey)) coord_err++;
            if (bus.hit_any !== (|bus.hit_vec)) cons_err++;
            if (ey < 24) begin
                vmem[ey][ex] = bus.hit_vec;
                imem[ey][ex] = bus.hit_idx;
            end
            for (int k = 0; k < 4; k++) hits_ch[k] += int'(bus.hit_vec[k]);
            any_cnt += int'(bus.hit_any);
            if (ex == 639) begin
                ex = 0;
                ey = (ey == 479) ? 0 : ey + 1;
            end else begin
                ex++;
            end
        end else begin
            if (bus.hit_valid !== 1'b0 || bus.hit_vec !== 4'd0 ||
                bus.hit_any !== 1'b0 || bus.hit_idx !== 2'd0) valid_err++;
            if (bus.pix_x !== last_x || bus.pix_y !== last_y) hold_err++;
        end
        last_x = bus.pix_x;
        last_y = bus.pix_y;
    endtask

    task automatic scan(input int n);
        repeat (n) do_pix(1'b0, 1'b1);
    endtask

    task automatic cfg_write(input logic [1:0] idx, input logic en, input int x, input int y,
                             input int w, input int h, input logic fs, input logic pv);
        bus.cfg_we  = 1'b1;
        bus.cfg_idx = idx;
        bus.cfg_en  = en;
        bus.cfg_x   = 10'(x);
        bus.cfg_y   = 10'(y);
        bus.cfg_w   = 10'(w);
        bus.cfg_h   = 10'(h);
        do_pix(fs, pv);
    endtask

    initial begin
        bus.frame_start = 1'b0;
        bus.pix_valid   = 1'b0;
        bus.cfg_we      = 1'b0;
        bus.cfg_idx     = '0;
        bus.cfg_en      = 1'b0;
        bus.cfg_x       = '0;
        bus.cfg_y       = '0;
        bus.cfg_w       = '0;
        bus.cfg_h       = '0;
        ex = 0;
        ey = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hit_valid", 32'(bus.hit_valid), 0);
        check("rst_hit_vec",   32'(bus.hit_vec),   0);
        check("rst_hit_any",   32'(bus.hit_any),   0);
        check("rst_hit_idx",   32'(bus.hit_idx),   0);
        check("rst_pix_x",     32'(bus.pix_x),     0);
        check("rst_pix_y",     32'(bus.pix_y),     0);
        rst    = 1'b0;
        last_x = '0;
        last_y = '0;

        // No config: coordinates step and wrap into line 1, no hits.
        clear_stats();
        do_pix(1'b1, 1'b0);
        scan(642);
        check("empty_coord_err", 32'(coord_err), 0);
        check("empty_valid_err", 32'(valid_err), 0);
        check("empty_hold_err",  32'(hold_err),  0);
        check("empty_any_cnt",   32'(any_cnt),   0);
        check("empty_wrap_x639", 32'(vmem[0][639]), 0);
        check("empty_last_x",    32'(bus.pix_x), 1);
        check("empty_last_y",    32'(bus.pix_y), 1);

        // Single rectangle ch0 {1,10,20,5,3}.
        cfg_write(2'd0, 1'b1, 10, 20, 5, 3, 1'b0, 1'b0);
        clear_stats();
        do_pix(1'b1, 1'b0);
        scan(24 * 640);
        check("ch0_hits",      32'(hits_ch[0]),   15);
        check("ch0_any_cnt",   32'(any_cnt),      15);
        check("ch0_coord_err", 32'(coord_err),    0);
        check("ch0_in_10_20",  32'(vmem[20][10]), 1);
        check("ch0_in_14_22",  32'(vmem[22][14]), 1);
        check("ch0_out_15_20", 32'(vmem[20][15]), 0);
        check("ch0_out_10_23", 32'(vmem[23][10]), 0);
        check("ch0_out_9_20",  32'(vmem[20][9]),  0);
        check("ch0_out_10_19", 32'(vmem[19][10]), 0);
        check("ch0_idx_14_22", 32'(imem[22][14]), 0);

        // Overlapping ch1 and right-edge clipped ch2.
        cfg_write(2'd1, 1'b1, 12, 21, 10, 10, 1'b0, 1'b0);
        cfg_write(2'd2, 1'b1, 635, 0, 20, 2, 1'b0, 1'b0);
        clear_stats();
        do_pix(1'b1, 1'b0);
        scan(24 * 640);
        check("ov_ch0_hits",   32'(hits_ch[0]),    15);
        check("ov_ch1_hits",   32'(hits_ch[1]),    30);
        check("ov_ch2_hits",   32'(hits_ch[2]),    10);
        check("ov_ch3_hits",   32'(hits_ch[3]),    0);
        check("ov_any_cnt",    32'(any_cnt),       49);
        check("ov_cons_err",   32'(cons_err),      0);
        check("ov_vec_12_21",  32'(vmem[21][12]),  3);
        check("ov_idx_12_21",  32'(imem[21][12]),  0);
        check("ov_vec_16_21",  32'(vmem[21][16]),  2);
        check("ov_idx_16_21",  32'(imem[21][16]),  1);
        check("clip_vec_0_1",  32'(vmem[1][0]),    0);
        check("clip_vec_14_1", 32'(vmem[1][14]),   0);
        check("clip_vec_635",  32'(vmem[0][635]),  4);
        check("clip_idx_635",  32'(imem[0][635]),  2);
        check("clip_vec_639_1", 32'(vmem[1][639]), 4);
        check("none_idx_0_0",  32'(imem[0][0]),    0);

        // Mid-frame write of ch0 x=100 at pixel (0,5): current frame keeps x=10.
        clear_stats();
        do_pix(1'b1, 1'b0);
        scan(5 * 640);
        cfg_write(2'd0, 1'b1, 100, 20, 5, 3, 1'b0, 1'b1);
        scan(16 * 640 - 1);
        check("mid_coord_err", 32'(coord_err),     0);
        check("mid_ch0_hits",  32'(hits_ch[0]),    5);
        check("mid_old_10_20", 32'(vmem[20][10]),  1);
        check("mid_new_100",   32'(vmem[20][100]), 0);

        // Write coincident with frame_start: this frame gets x=100, not x=200.
        clear_stats();
        cfg_write(2'd0, 1'b1, 200, 0, 5, 3, 1'b1, 1'b0);
        scan(21 * 640);
        check("coin_ch0_hits", 32'(hits_ch[0]),    5);
        check("coin_vec_100",  32'(vmem[20][100]), 1);
        check("coin_vec_10",   32'(vmem[20][10]),  0);
        check("coin_vec_200",  32'(vmem[0][200]),  0);

        // Following frame picks up x=200; ch3 added ahead of it.
        cfg_write(2'd3, 1'b1, 30, 0, 4, 1, 1'b0, 1'b0);
        clear_stats();
        do_pix(1'b1, 1'b0);
        scan(640);
        check("next_vec_200",  32'(vmem[0][200]), 1);
        check("next_ch0_hits", 32'(hits_ch[0]),   5);
        check("next_ch3_hits", 32'(hits_ch[3]),   4);
        check("next_vec_31",   32'(vmem[0][31]),  8);
        check("next_idx_31",   32'(imem[0][31]),  3);

        // Gapped strobes, frame_start together with the first pixel.
        clear_stats();
        do_pix(1'b1, 1'b1);
        repeat (2) do_pix(1'b0, 1'b0);
        for (int i = 1; i < 40; i++) begin
            do_pix(1'b0, 1'b1);
            repeat (2) do_pix(1'b0, 1'b0);
        end
        check("gap_coord_err", 32'(coord_err),   0);
        check("gap_valid_err", 32'(valid_err),   0);
        check("gap_hold_err",  32'(hold_err),    0);
        check("gap_ch3_hits",  32'(hits_ch[3]),  4);
        check("gap_vec_31",    32'(vmem[0][31]), 8);
        check("gap_last_x",    32'(bus.pix_x),   39);

        // Reset with a pixel strobed: everything clears.
        bus.pix_valid = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.pix_valid = 1'b0;
        check("mrst_hit_valid", 32'(bus.hit_valid), 0);
        check("mrst_hit_vec",   32'(bus.hit_vec),   0);
        check("mrst_hit_any",   32'(bus.hit_any),   0);
        check("mrst_hit_idx",   32'(bus.hit_idx),   0);
        check("mrst_pix_x",     32'(bus.pix_x),     0);
        check("mrst_pix_y",     32'(bus.pix_y),     0);
        last_x = '0;
        last_y = '0;
        ex = 0;
        ey = 0;
        clear_stats();
        scan(40);
        check("post_first_vec", 32'(vmem[0][0]), 0);
        check("post_coord_err", 32'(coord_err),  0);
        check("post_any_cnt",   32'(any_cnt),    0);
        clear_stats();
        do_pix(1'b1, 1'b0);
        scan(40);
        check("post_fs_ch3",    32'(hits_ch[3]), 0);
        check("post_fs_any",    32'(any_cnt),    0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rect_region_scanner.md
Name: rect_region_scanner

Overview:
- Multi-rectangle hit detector for the VGA pixel stream.
- Tracks the current pixel with internal x/y counters driven by a pixel strobe, so no per-row address multiplication is needed. Flags which of NUM_RECT programmable rectangles contain that pixel.
- Sits between the VGA timing generator and the colour mux. Drives bike, wall and score-box overlays.

Parameters:
- SCREEN_W, 640, active pixels per line.
- SCREEN_H, 480, active lines per frame.
- DIM_W, 10, width of all coordinate and size fields.
- NUM_RECT, 4, number of rectangle channels (1..16).
- IDX_W, 2, width of rectangle index; equals clog2(NUM_RECT), minimum 1.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- frame_start  in  1  one-cycle pulse; the next pix_valid is pixel (0,0)
- pix_valid  in  1  advance strobe; current pixel is valid this cycle
- cfg_we  in  1  write shadow config for channel cfg_idx
- cfg_idx  in  IDX_W  channel selected for write
- cfg_en  in  1  channel enable written with config
- cfg_x, cfg_y  in  DIM_W  rectangle top-left corner
- cfg_w, cfg_h  in  DIM_W  rectangle width/height in pixels
- hit_valid  out  1  registered pix_valid, one cycle later
- hit_vec  out  NUM_RECT  per-channel containment for that pixel
- hit_any  out  1  OR of hit_vec
- hit_idx  out  IDX_W  lowest-numbered hitting channel (0 if none)
- pix_x, pix_y  out  DIM_W  coordinates of the pixel reported this cycle

Behaviour:
- Reset (synchronous, active-high): all outputs 0; x/y counters 0; shadow and active config cleared (all channels disabled); pending-frame flag cleared.
- Counters:
  - On pix_valid, x increments; at x==SCREEN_W-1, x goes to 0 and y increments.
  - At y==SCREEN_H-1 with x==SCREEN_W-1, both wrap to 0.
  - Without pix_valid, the counters hold.
- frame_start:
  - Sets counters to (0,0) for the next pix_valid.
  - frame_start and pix_valid in the same cycle: that pixel is (0,0), and the counters advance to (1,0).
  - Overrides any pending wrap.
- Config double-buffering:
  - cfg_we writes the shadow entry cfg_idx in one cycle. Writes with cfg_idx >= NUM_RECT are ignored.
  - On frame_start, all shadow entries copy to active in the same cycle, so no mid-frame tearing.
  - cfg_we and frame_start in the same cycle: the copy takes the old shadow value; the new write lands in shadow and is applied at the following frame_start.
- Hit rule, evaluated for channel k on active config:
  - en_k && x>=x_k && x<x_k+w_k && y>=y_k && y<y_k+h_k.
  - Left/top edges are inclusive; right/bottom edges are exclusive.
  - Sums are computed at DIM_W+1 bits, so there is no wrap. Rectangles extending past the screen are clipped naturally.
  - w_k==0 or h_k==0: never hits.
- Latency: the pixel strobed at cycle t is reported at t+1 with hit_valid=1, pix_x/pix_y equal to that pixel, and hit_vec/hit_any/hit_idx all registered together.
- Output timing:
  - When hit_valid=0, hit_vec/hit_any are 0 and hit_idx is 0.
  - pix_x/pix_y hold their last value.
- hit_idx: priority encoder, lowest index wins.
- Reset mid-frame: outputs are 0 the next cycle, config is lost, and the counters restart at (0,0) without needing frame_start.

Decomposition:
- Shared package vga_pkg:
  - SCREEN_W/SCREEN_H constants.
  - Coordinate typedef (DIM_W bits).
  - rect_cfg_t struct {en, x, y, w, h}.
- One sub-module, rect_contains: purely combinational single-rectangle compare (x, y, rect_cfg_t -> hit). Instantiated NUM_RECT times in a generate loop.
- The top level owns the counters, the shadow/active registers and the priority encoder.

Test Plan:
- Reset, then frame_start, then 640*480 continuous pix_valid with no config -> hit_valid every cycle after the first; hit_vec=0 throughout; pix_x/pix_y wrap (639,0)->(0,1) and (639,479)->(0,0).
- ch0 = {en=1, x=10, y=20, w=5, h=3}, then frame_start, full frame -> exactly 15 hits:
  - x in 10..14, y in 20..22.
  - (15,20) and (10,23) miss.
  - hit_idx=0.
- ch1 = {1, 12, 21, 10, 10} overlapping ch0 -> at (12,21) hit_vec=4'b0011 and hit_idx=0; at (16,21) hit_vec=4'b0010 and hit_idx=1.
- ch2 = {1, 635, 478, 20, 20} -> hits only x in 635..639, y in 478..479 (10 pixels); no wrap to x=0.
- Mid-frame write of ch0 x=100 at pixel (0,5), then cfg_we coincident with frame_start -> rest of the current frame still uses x=10; the next frame uses x=100 only if the write preceded frame_start, otherwise the frame after that.
- Gapped pix_valid (1 of every 3 cycles), then reset asserted at pixel (300,200) -> counters hold during gaps; one cycle after reset, all outputs are 0; the next pix_valid reports (0,0) and config is cleared.
